// File: rtl/sobel_pkg.sv
// sobel_pkg: types and frame-size defaults shared across the Sobel pipeline stages.
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_e;
  localparam int PIX_W = 8;
  localparam int MAX_ROW_DEF = 540;
  localparam int MAX_COL_DEF = 540;
  localparam int ADDR_W_DEF = 19;
  localparam int RD_LAT_DEF = 1;
endpackage

// File: rtl/sobel_frame_reader_if.sv
// sobel_frame_reader_if: controller, frame-memory and pixel-stream signals of the frame reader.
interface sobel_frame_reader_if #(parameter int ADDR_W = sobel_pkg::ADDR_W_DEF);
  logic START_I;
  logic HOLD_I;
  logic [ADDR_W-1:0] MEM_ADDR_O;
  logic MEM_RD_EN_O;
  logic [sobel_pkg::PIX_W-1:0] MEM_DATA_I;
  logic [sobel_pkg::PIX_W-1:0] DATA_O;
  logic DATA_EN_O;
  logic LAST_O;
  logic BUSY_O;
  logic DONE_O;
  modport master (
    input START_I, HOLD_I, MEM_DATA_I,
    output MEM_ADDR_O, MEM_RD_EN_O, DATA_O, DATA_EN_O, LAST_O, BUSY_O, DONE_O
  );
  modport slave (
    output START_I, HOLD_I, MEM_DATA_I,
    input MEM_ADDR_O, MEM_RD_EN_O, DATA_O, DATA_EN_O, LAST_O, BUSY_O, DONE_O
  );
endinterface

// File: rtl/sobel_frame_reader_valid_pipe.sv
// rd_valid_pipe: RD_LAT-deep {valid,last} shift register tracking reads in flight to the memory.
module rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_v,
  input  logic in_l,
  output logic out_v,
  output logic out_l
);
  logic [RD_LAT-1:0] v, l;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      l <= '0;
    end else begin
      v <= RD_LAT'({v, in_v});
      l <= RD_LAT'({l, in_l});
    end
  end
  assign out_v = v[RD_LAT-1];
  assign out_l = l[RD_LAT-1];
endmodule

// File: rtl/sobel_frame_reader.sv
// sobel_frame_reader: streams one frame from memory in raster order, absorbing a fixed read latency.
module sobel_frame_reader
  import sobel_pkg::*;
#(
  parameter int MAX_ROW = MAX_ROW_DEF,
  parameter int MAX_COL = MAX_COL_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  sobel_frame_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ROW * MAX_COL - 1);
  rd_state_e state, nxt;
  logic [ADDR_W-1:0] addr;
  logic rd_en, last_rd, tail_v, tail_l;
  assign rd_en = (state == READ) & ~bus.HOLD_I;
  assign last_rd = rd_en & (addr == LAST_ADDR);
  assign bus.MEM_RD_EN_O = rd_en;
  assign bus.MEM_ADDR_O = addr;
  // DRAIN ends on the edge after the LAST_O beat, so the pipeline is empty by then
  always_comb begin
    nxt = state == IDLE  ? (bus.START_I ? READ : IDLE) :
          state == READ  ? (last_rd ? DRAIN : READ) :
          state == DRAIN ? (bus.LAST_O ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      addr <= '0;
      bus.DATA_O <= '0;
      bus.DATA_EN_O <= 1'b0;
      bus.LAST_O <= 1'b0;
      bus.BUSY_O <= 1'b0;
      bus.DONE_O <= 1'b0;
    end else begin
      state <= nxt;
      addr <= state == IDLE ? '0 : rd_en ? addr + 1'b1 : addr;
      bus.DATA_O <= tail_v ? bus.MEM_DATA_I : bus.DATA_O;
      bus.DATA_EN_O <= tail_v;
      bus.LAST_O <= tail_v & tail_l;
      bus.BUSY_O <= nxt != IDLE;
      bus.DONE_O <= nxt == DONE;
    end
  end
  rd_valid_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk(CLK),
    .rst_n(RST_N),
    .in_v(rd_en),
    .in_l(last_rd),
    .out_v(tail_v),
    .out_l(tail_l)
  );
endmodule
